// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register with
// stall/flush control, and saturating stall/redirect performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCWrite,
    input  logic             IFIDWrite,
    input  logic             PCSrc,
    input  logic [31:0]      branchTarget,
    output logic [31:0]      imemAddr,
    input  logic [31:0]      imemData,
    output logic [31:0]      IFIDInstr,
    output logic [31:0]      IFIDPC4,
    output logic             IFIDValid,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc_plus4;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        stall_d = stall_q;
        flush_d = flush_q;

        // A redirect overrides both hazard enables.
        if (PCSrc) begin
            pc_d = {branchTarget[31:2], 2'b00};
        end else if (PCWrite) begin
            pc_d = pc_plus4;
        end

        if (PCSrc) begin
            instr_d = 32'h00000000;
            pc4_d   = 32'h00000000;
            valid_d = 1'b0;
        end else if (IFIDWrite) begin
            instr_d = imemData;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end

        if (!PCWrite && !PCSrc && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (PCSrc && (flush_q != {CNT_W{1'b1}})) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h00000000;
            pc4_q   <= 32'h00000000;
            valid_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign imemAddr   = pc_q;
    assign IFIDInstr  = instr_q;
    assign IFIDPC4    = pc4_q;
    assign IFIDValid  = valid_q;
    assign stallCount = stall_q;
    assign flushCount = flush_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL provide parameter CNT_W, default 16, meaning the width of each performance counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port PCWrite, input, 1, PC update enable from the hazard check; 0 means stall.
REQ-006 SHALL have port IFIDWrite, input, 1, IF/ID register load enable from the hazard check; 0 means hold.
REQ-007 SHALL have port PCSrc, input, 1, taken branch or jump redirect from a later stage.
REQ-008 SHALL have port branchTarget, input, 32, the redirect address.
REQ-009 SHALL have port imemAddr, output, 32, the instruction memory address.
REQ-010 SHALL have port imemData, input, 32, the instruction word, valid in the same cycle as imemAddr.
REQ-011 SHALL have port IFIDInstr, output, 32, the registered instruction passed to decode.
REQ-012 SHALL have port IFIDPC4, output, 32, the registered PC+4 of that instruction.
REQ-013 SHALL have port IFIDValid, output, 1, which is 1 when IFIDInstr is a real fetched instruction.
REQ-014 SHALL have port stallCount, output, CNT_W, the number of stall cycles.
REQ-015 SHALL have port flushCount, output, CNT_W, the number of redirect cycles.

Function
REQ-016 SHALL drive imemAddr combinationally equal to the PC register.
REQ-017 SHALL compute the PC increment as PC+4 modulo 2^32; 32'hFFFFFFFC+4 wraps to 32'h00000000 with no flag.
REQ-018 SHALL apply this PC next-state priority: rst, then PCSrc, then PCWrite, then hold.
REQ-019 SHALL load PC with {branchTarget[31:2],2'b00} when PCSrc=1, regardless of PCWrite.
REQ-020 SHALL load PC with PC+4 when PCSrc=0 and PCWrite=1, and hold PC when PCSrc=0 and PCWrite=0.
REQ-021 SHALL apply this IF/ID next-state priority: rst, then PCSrc (flush), then IFIDWrite, then hold.
REQ-022 SHALL, on a flush, load IFIDInstr=32'h00000000 (nop), IFIDPC4=0 and IFIDValid=0, regardless of IFIDWrite.
REQ-023 SHALL, when PCSrc=0 and IFIDWrite=1, load IFIDInstr=imemData, IFIDPC4=PC+4 and IFIDValid=1.
REQ-024 SHALL, when PCSrc=0 and IFIDWrite=0, hold all three IF/ID outputs unchanged.
REQ-025 SHALL obey PCWrite and IFIDWrite independently; a mixed setting is legal and each register follows only its own enable.
REQ-026 SHALL give a fetch latency of one cycle: the instruction at PC appears on IFIDInstr after the next rising edge.
REQ-027 SHALL increment stallCount on each non-reset edge where PCWrite=0 and PCSrc=0.
REQ-028 SHALL increment flushCount on each non-reset edge where PCSrc=1.
REQ-029 SHALL make both counters saturate at all-ones and never wrap.
REQ-030 SHALL contain no combinational path from any input to IFIDInstr, IFIDPC4, IFIDValid, stallCount or flushCount.

Reset
REQ-031 SHALL, on each rising edge with rst=1, set PC=RESET_PC, IFIDInstr=0, IFIDPC4=0, IFIDValid=0, stallCount=0 and flushCount=0.
REQ-032 SHALL give rst priority over PCSrc, PCWrite and IFIDWrite.
REQ-033 SHALL abandon any operation in progress when rst is asserted, including a stall or redirect in the same cycle.
REQ-034 SHALL resume fetching from RESET_PC on the first edge after rst deasserts, with PCWrite=1.

Verification
REQ-035 SHALL verify sequential fetch: after reset, 3 cycles with PCWrite=IFIDWrite=1 and PCSrc=0 -> imemAddr 0,4,8,12 and IFIDPC4 4,8,12 with IFIDValid=1.
REQ-036 SHALL verify a load-use stall: PCWrite=IFIDWrite=0 for 2 cycles at PC=8 -> PC stays 8, IF/ID holds, stallCount=2.
REQ-037 SHALL verify redirect priority: PCSrc=1 with branchTarget=32'h00000043 and PCWrite=0 -> PC=32'h00000040, IFIDValid=0, IFIDInstr=0, flushCount=1, stallCount unchanged.
REQ-038 SHALL verify wrap: PC=32'hFFFFFFFC with PCWrite=1 -> PC=0 and IFIDPC4=0.
REQ-039 SHALL verify counter saturation: with CNT_W=4, 20 stall cycles -> stallCount=4'hF.
REQ-040 SHALL verify reset mid-stall: rst=1 while PCWrite=0 and PCSrc=1 -> all outputs at reset values and PC=RESET_PC.
